// File: rtl/fetch_if.sv
// fetch_if -- bundle between the fetch stage and its environment
// (decode/debug side).
//
// Control and debug inputs into fetch:
//   debug, hz, branch_taken, branoff[7:0], dbg_we, dbg_addr[7:0],
//   dbg_wdata[31:0]
//
// Pipeline and status outputs from fetch:
//   IF_ID_ins[31:0], IF_ID_pres_adr[7:0], IF_ID_valid, pc[7:0],
//   stall_cnt[15:0], flush_cnt[15:0]
//
// Modports:
//   master -- the environment (decode, debugger, testbench)
//   slave  -- the fetch stage
interface fetch_if;
   logic        debug;
   logic        hz;
   logic        branch_taken;
   logic [7:0]  branoff;
   logic        dbg_we;
   logic [7:0]  dbg_addr;
   logic [31:0] dbg_wdata;
   logic [31:0] IF_ID_ins;
   logic [7:0]  IF_ID_pres_adr;
   logic        IF_ID_valid;
   logic [7:0]  pc;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;

   modport master (
      output debug, hz, branch_taken, branoff, dbg_we, dbg_addr, dbg_wdata,
      input  IF_ID_ins, IF_ID_pres_adr, IF_ID_valid, pc, stall_cnt, flush_cnt
   );

   modport slave (
      input  debug, hz, branch_taken, branoff, dbg_we, dbg_addr, dbg_wdata,
      output IF_ID_ins, IF_ID_pres_adr, IF_ID_valid, pc, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch stage with a 64x32 instruction memory.
//
// The memory has a combinational read, indexed by pc[7:2]. A debugger
// loads it while the pipeline is frozen (debug=1). Each rising edge does
// one of four things, in priority order:
//   1. debug        - freeze
//   2. hz           - stall
//   3. branch_taken - redirect, and insert a bubble
//   4. otherwise    - sequential fetch
//
// Ports:
//   clk  - system clock, rising edge
//   Rst  - asynchronous, active-high reset (the memory is not reset)
//   bus  - fetch_if.slave; see rtl/fetch_if.sv for the signal list
//
// Optional feature:
//   FETCH_PERF_CNT_EN - when defined, adds saturating stall/redirect
//   counters. When it is undefined, stall_cnt and flush_cnt are tied to
//   zero and no counter flops exist.
module fetch_stage (
   input  logic    clk,
   input  logic    Rst,
   fetch_if.slave  bus
);

   logic [31:0] imem [0:63];

   logic [7:0]  pc_q,        pc_d;
   logic [31:0] if_ins_q,    if_ins_d;
   logic [7:0]  if_adr_q,    if_adr_d;
   logic        if_valid_q,  if_valid_d;

   // Address bits below word granularity are don't-care by design.
   logic unused_bits_s;
   assign unused_bits_s = ^{bus.dbg_addr[1:0], bus.branoff[1:0]};

   // Debug write port. The memory is deliberately not reset, so its
   // contents survive Rst.
   always_ff @(posedge clk) begin
      if (bus.debug && bus.dbg_we) begin
         imem[bus.dbg_addr[7:2]] <= bus.dbg_wdata;
      end
   end

   // Next-state selection for the PC and the IF/ID registers.
   always_comb begin
      pc_d       = pc_q;
      if_ins_d   = if_ins_q;
      if_adr_d   = if_adr_q;
      if_valid_d = if_valid_q;
      if (bus.debug) begin
         pc_d = pc_q;
      end else if (bus.hz) begin
         // A redirect arriving during a hazard is dropped here.
         // Decode re-asserts it once the hazard clears.
         pc_d = pc_q;
      end else if (bus.branch_taken) begin
         pc_d       = {bus.branoff[7:2], 2'b00};
         if_ins_d   = 32'h0000_0000;
         if_adr_d   = pc_q;
         if_valid_d = 1'b0;
      end else begin
         pc_d       = pc_q + 8'd4;
         if_ins_d   = imem[pc_q[7:2]];
         if_adr_d   = pc_q;
         if_valid_d = 1'b1;
      end
   end

   // Pipeline state registers.
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         pc_q       <= 8'h00;
         if_ins_q   <= 32'h0000_0000;
         if_adr_q   <= 8'h00;
         if_valid_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         if_ins_q   <= if_ins_d;
         if_adr_q   <= if_adr_d;
         if_valid_q <= if_valid_d;
      end
   end

   assign bus.pc             = pc_q;
   assign bus.IF_ID_ins      = if_ins_q;
   assign bus.IF_ID_pres_adr = if_adr_q;
   assign bus.IF_ID_valid    = if_valid_q;

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   // Saturating counters for hazard stalls and redirects taken.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!bus.debug && bus.hz) begin
         if (stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
         end else begin
            stall_cnt_d = stall_cnt_q;
         end
      end else if (!bus.debug && bus.branch_taken) begin
         if (flush_cnt_q != 16'hFFFF) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
         end else begin
            flush_cnt_d = flush_cnt_q;
         end
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         stall_cnt_q <= 16'h0000;
         flush_cnt_q <= 16'h0000;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;
`else
   assign bus.stall_cnt = 16'h0000;
   assign bus.flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

   logic clk = 1'b0;
   logic Rst = 1'b1;
   int   checks = 0;
   int   passed = 0;

`ifdef FETCH_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   fetch_if bus ();

   fetch_stage dut (
      .clk (clk),
      .Rst (Rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Advance one rising edge, then settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.debug = 1'b0; bus.hz = 1'b0; bus.branch_taken = 1'b0; bus.branoff = 8'h00;
      bus.dbg_we = 1'b0; bus.dbg_addr = 8'h00; bus.dbg_wdata = 32'h0;
      Rst = 1'b1;
      tick(); tick();
      checks++; if (bus.pc !== 8'h00) $display("FAIL reset_pc got %h want 00", bus.pc); else passed++;
      checks++; if (bus.IF_ID_ins !== 32'h0) $display("FAIL reset_ins got %h want 0", bus.IF_ID_ins); else passed++;
      checks++; if (bus.IF_ID_pres_adr !== 8'h00) $display("FAIL reset_adr got %h want 00", bus.IF_ID_pres_adr); else passed++;
      checks++; if (bus.IF_ID_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.IF_ID_valid); else passed++;
      checks++; if (bus.stall_cnt !== 16'h0) $display("FAIL reset_stall_cnt got %h want 0", bus.stall_cnt); else passed++;
      checks++; if (bus.flush_cnt !== 16'h0) $display("FAIL reset_flush_cnt got %h want 0", bus.flush_cnt); else passed++;
      Rst = 1'b0;
   endtask

   task automatic test_debug_load();
      logic [7:0]  addrs [6] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h20, 8'hFC};
      logic [31:0] datas [6] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h99, 32'hFF00FF00};
      bus.debug = 1'b1;
      for (int i = 0; i < 6; i++) begin
         bus.dbg_we = 1'b1; bus.dbg_addr = addrs[i]; bus.dbg_wdata = datas[i];
         tick();
         checks++; if (bus.pc !== 8'h00) $display("FAIL debug_pc_hold[%0d] got %h want 00", i, bus.pc); else passed++;
         checks++; if (bus.IF_ID_valid !== 1'b0) $display("FAIL debug_valid_hold[%0d] got %b want 0", i, bus.IF_ID_valid); else passed++;
      end
      bus.dbg_we = 1'b0;
      bus.debug = 1'b0;
   endtask

   // Fetch n words starting at the held pc and compare against the table.
   task automatic test_fetch_seq(input int first, input int n);
      logic [31:0] ins_tab [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
      logic [7:0]  adr_tab [4] = '{8'h00, 8'h04, 8'h08, 8'h0C};
      for (int i = first; i < first + n; i++) begin
         tick();
         checks++; if (bus.IF_ID_ins !== ins_tab[i]) $display("FAIL seq_ins[%0d] got %h want %h", i, bus.IF_ID_ins, ins_tab[i]); else passed++;
         checks++; if (bus.IF_ID_pres_adr !== adr_tab[i]) $display("FAIL seq_adr[%0d] got %h want %h", i, bus.IF_ID_pres_adr, adr_tab[i]); else passed++;
         checks++; if (bus.IF_ID_valid !== 1'b1) $display("FAIL seq_valid[%0d] got %b want 1", i, bus.IF_ID_valid); else passed++;
         checks++; if (bus.pc !== adr_tab[i] + 8'd4) $display("FAIL seq_pc[%0d] got %h want %h", i, bus.pc, adr_tab[i] + 8'd4); else passed++;
      end
   endtask

   task automatic test_stall();
      bus.hz = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (bus.pc !== 8'h08) $display("FAIL stall_pc[%0d] got %h want 08", i, bus.pc); else passed++;
         checks++; if (bus.IF_ID_ins !== 32'h22) $display("FAIL stall_ins[%0d] got %h want 22", i, bus.IF_ID_ins); else passed++;
         checks++; if (bus.IF_ID_pres_adr !== 8'h04) $display("FAIL stall_adr[%0d] got %h want 04", i, bus.IF_ID_pres_adr); else passed++;
         checks++; if (bus.IF_ID_valid !== 1'b1) $display("FAIL stall_valid[%0d] got %b want 1", i, bus.IF_ID_valid); else passed++;
      end
      bus.hz = 1'b0;
      checks++; if (bus.stall_cnt !== (PERF ? 16'd3 : 16'd0)) $display("FAIL stall_cnt got %0d want %0d", bus.stall_cnt, PERF ? 3 : 0); else passed++;
   endtask

   task automatic test_branch();
      bus.branch_taken = 1'b1; bus.branoff = 8'h21;
      tick();
      bus.branch_taken = 1'b0;
      checks++; if (bus.pc !== 8'h20) $display("FAIL branch_pc got %h want 20", bus.pc); else passed++;
      checks++; if (bus.IF_ID_ins !== 32'h0) $display("FAIL branch_ins got %h want 0", bus.IF_ID_ins); else passed++;
      checks++; if (bus.IF_ID_valid !== 1'b0) $display("FAIL branch_valid got %b want 0", bus.IF_ID_valid); else passed++;
      checks++; if (bus.IF_ID_pres_adr !== 8'h10) $display("FAIL branch_adr got %h want 10", bus.IF_ID_pres_adr); else passed++;
      checks++; if (bus.flush_cnt !== (PERF ? 16'd1 : 16'd0)) $display("FAIL branch_flush_cnt got %0d want %0d", bus.flush_cnt, PERF ? 1 : 0); else passed++;
      tick();
      checks++; if (bus.IF_ID_ins !== 32'h99) $display("FAIL branch_target_ins got %h want 99", bus.IF_ID_ins); else passed++;
      checks++; if (bus.IF_ID_pres_adr !== 8'h20) $display("FAIL branch_target_adr got %h want 20", bus.IF_ID_pres_adr); else passed++;
      checks++; if (bus.pc !== 8'h24) $display("FAIL branch_target_pc got %h want 24", bus.pc); else passed++;
   endtask

   task automatic test_hz_branch();
      bus.hz = 1'b1; bus.branch_taken = 1'b1; bus.branoff = 8'h40;
      tick();
      bus.hz = 1'b0; bus.branch_taken = 1'b0;
      checks++; if (bus.pc !== 8'h24) $display("FAIL hzbr_pc got %h want 24", bus.pc); else passed++;
      checks++; if (bus.IF_ID_ins !== 32'h99) $display("FAIL hzbr_ins got %h want 99", bus.IF_ID_ins); else passed++;
      checks++; if (bus.IF_ID_valid !== 1'b1) $display("FAIL hzbr_valid got %b want 1", bus.IF_ID_valid); else passed++;
      checks++; if (bus.flush_cnt !== (PERF ? 16'd1 : 16'd0)) $display("FAIL hzbr_flush_cnt got %0d want %0d", bus.flush_cnt, PERF ? 1 : 0); else passed++;
      checks++; if (bus.stall_cnt !== (PERF ? 16'd4 : 16'd0)) $display("FAIL hzbr_stall_cnt got %0d want %0d", bus.stall_cnt, PERF ? 4 : 0); else passed++;
   endtask

   task automatic test_wrap();
      bus.branch_taken = 1'b1; bus.branoff = 8'hFE;
      tick();
      bus.branch_taken = 1'b0;
      checks++; if (bus.pc !== 8'hFC) $display("FAIL wrap_load_pc got %h want FC", bus.pc); else passed++;
      tick();
      checks++; if (bus.pc !== 8'h00) $display("FAIL wrap_pc got %h want 00", bus.pc); else passed++;
      checks++; if (bus.IF_ID_pres_adr !== 8'hFC) $display("FAIL wrap_adr got %h want FC", bus.IF_ID_pres_adr); else passed++;
      checks++; if (bus.IF_ID_ins !== 32'hFF00FF00) $display("FAIL wrap_ins got %h want FF00FF00", bus.IF_ID_ins); else passed++;
      checks++; if (bus.IF_ID_valid !== 1'b1) $display("FAIL wrap_valid got %b want 1", bus.IF_ID_valid); else passed++;
      checks++; if (bus.flush_cnt !== (PERF ? 16'd2 : 16'd0)) $display("FAIL wrap_flush_cnt got %0d want %0d", bus.flush_cnt, PERF ? 2 : 0); else passed++;
   endtask

   task automatic test_debug_visibility();
      // Overwrite the word at the held pc, then try a write with debug low.
      bus.debug = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 8'h01; bus.dbg_wdata = 32'hAB;
      tick();
      checks++; if (bus.pc !== 8'h00) $display("FAIL dbgvis_pc_hold got %h want 00", bus.pc); else passed++;
      checks++; if (bus.IF_ID_ins !== 32'hFF00FF00) $display("FAIL dbgvis_ins_hold got %h want FF00FF00", bus.IF_ID_ins); else passed++;
      bus.debug = 1'b0; bus.dbg_addr = 8'h04; bus.dbg_wdata = 32'hDEAD;
      tick();
      bus.dbg_we = 1'b0;
      checks++; if (bus.IF_ID_ins !== 32'hAB) $display("FAIL dbgvis_ins got %h want AB", bus.IF_ID_ins); else passed++;
      checks++; if (bus.IF_ID_pres_adr !== 8'h00) $display("FAIL dbgvis_adr got %h want 00", bus.IF_ID_pres_adr); else passed++;
      tick();
      checks++; if (bus.IF_ID_ins !== 32'h22) $display("FAIL dbgwe_ignored got %h want 22", bus.IF_ID_ins); else passed++;
      checks++; if (bus.pc !== 8'h08) $display("FAIL dbgvis_pc got %h want 08", bus.pc); else passed++;
   endtask

   task automatic test_reset_mid_stall();
      bus.hz = 1'b1;
      tick();
      checks++; if (bus.pc !== 8'h08) $display("FAIL rststall_pre_pc got %h want 08", bus.pc); else passed++;
      #3 Rst = 1'b1;
      #1;
      checks++; if (bus.pc !== 8'h00) $display("FAIL rststall_pc got %h want 00", bus.pc); else passed++;
      checks++; if (bus.IF_ID_ins !== 32'h0) $display("FAIL rststall_ins got %h want 0", bus.IF_ID_ins); else passed++;
      checks++; if (bus.IF_ID_valid !== 1'b0) $display("FAIL rststall_valid got %b want 0", bus.IF_ID_valid); else passed++;
      checks++; if (bus.IF_ID_pres_adr !== 8'h00) $display("FAIL rststall_adr got %h want 00", bus.IF_ID_pres_adr); else passed++;
      checks++; if (bus.stall_cnt !== 16'h0) $display("FAIL rststall_stall_cnt got %h want 0", bus.stall_cnt); else passed++;
      checks++; if (bus.flush_cnt !== 16'h0) $display("FAIL rststall_flush_cnt got %h want 0", bus.flush_cnt); else passed++;
      bus.hz = 1'b0; bus.branch_taken = 1'b1; bus.branoff = 8'h80;
      tick();
      checks++; if (bus.pc !== 8'h00) $display("FAIL rst_priority_pc got %h want 00", bus.pc); else passed++;
      bus.branch_taken = 1'b0;
      Rst = 1'b0;
      tick();
      checks++; if (bus.IF_ID_ins !== 32'hAB) $display("FAIL rst_retain_ins got %h want AB", bus.IF_ID_ins); else passed++;
      checks++; if (bus.IF_ID_pres_adr !== 8'h00) $display("FAIL rst_restart_adr got %h want 00", bus.IF_ID_pres_adr); else passed++;
      checks++; if (bus.IF_ID_valid !== 1'b1) $display("FAIL rst_restart_valid got %b want 1", bus.IF_ID_valid); else passed++;
      checks++; if (bus.pc !== 8'h04) $display("FAIL rst_restart_pc got %h want 04", bus.pc); else passed++;
   endtask

   initial begin
      test_reset();
      test_debug_load();
      test_fetch_seq(0, 2);
      test_stall();
      test_fetch_seq(2, 2);
      test_branch();
      test_hz_branch();
      test_wrap();
      test_debug_visibility();
      test_reset_mid_stall();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
